// File: rtl/mm_pkg.sv
// Shared colour type, colour codes, peg geometry and the code-to-RGB palette
// used by the Mastermind board renderer and its feedback peg decoder.
package mm_pkg;

   typedef logic [11:0] rgb_t;

   typedef enum logic [1:0] {
      REG_NONE = 2'd0,
      REG_SLOT = 2'd1,
      REG_FB   = 2'd2
   } region_t;

   localparam int unsigned CODE_NONE    = 0;
   localparam int unsigned CODE_BLUE    = 1;
   localparam int unsigned CODE_GREEN   = 2;
   localparam int unsigned CODE_CYAN    = 3;
   localparam int unsigned CODE_RED     = 4;
   localparam int unsigned CODE_YELLOW  = 5;
   localparam int unsigned CODE_MAGENTA = 6;

   localparam rgb_t RGB_BLACK = 12'h000;
   localparam rgb_t RGB_WHITE = 12'hFFF;
   localparam rgb_t RGB_GREY  = 12'h888;
   localparam rgb_t RGB_DARK  = 12'h222;
   localparam rgb_t RGB_RED   = 12'hF00;

   localparam int PEG_PITCH = 24;
   localparam int PEG_CTR   = 12;
   localparam int PEG_R2    = 49;

   function automatic rgb_t palette(input int unsigned code);
      rgb_t c;
      case (code)
         CODE_NONE:    c = RGB_BLACK;
         CODE_BLUE:    c = 12'h00F;
         CODE_GREEN:   c = 12'h0F0;
         CODE_CYAN:    c = 12'h0FF;
         CODE_RED:     c = 12'hF00;
         CODE_YELLOW:  c = 12'hFF0;
         CODE_MAGENTA: c = 12'hF0F;
         default:      c = RGB_GREY;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mm_feedback_pegs.sv
// Feedback peg decoder (present only with MM_FEEDBACK_PEGS_EN): cell-local pixel
// coords -> peg hit and colour from the row's black/white score. Combinational.
`ifdef MM_FEEDBACK_PEGS_EN
module mm_feedback_pegs
   import mm_pkg::*;
#(
   parameter int COLS = 4,
   parameter int FBW  = $clog2(COLS + 1)
) (
   input  logic [FBW-1:0] black,
   input  logic [FBW-1:0] white,
   input  logic [9:0]     lx,
   input  logic [9:0]     ly,
   output logic           hit,
   output rgb_t           rgb
);

   localparam int NPC = (COLS + 1) / 2;

   int lxi;
   int lyi;
   int pc;
   int xbase;
   int ox;
   int oy;
   int k;

   always_comb begin
      lxi   = int'(lx);
      lyi   = int'(ly);
      pc    = 0;
      xbase = 0;
      for (int i = 1; i < NPC; i++) begin
         if (lxi >= i * PEG_PITCH) begin
            pc    = i;
            xbase = i * PEG_PITCH;
         end
      end
      ox = lxi - xbase - PEG_CTR;
      oy = (lyi >= PEG_PITCH) ? (lyi - PEG_PITCH - PEG_CTR) : (lyi - PEG_CTR);
      // pegs are numbered across the top line first, then the bottom line
      k  = (lyi >= PEG_PITCH) ? (NPC + pc) : pc;

      hit = (lxi < NPC * PEG_PITCH) && (lyi < 2 * PEG_PITCH) &&
            ((ox * ox + oy * oy) <= PEG_R2);

      if (k < int'(black)) begin
         rgb = RGB_RED;
      end else if (k < int'(black) + int'(white)) begin
         rgb = RGB_WHITE;
      end else begin
         rgb = RGB_DARK;
      end
   end

endmodule
`endif

// File: rtl/mastermind_board_renderer.sv
// Mastermind board renderer: locate -> classify -> colour pipeline, 2 clk pixel latency.
// Define MM_FEEDBACK_PEGS_EN to draw black/white feedback pegs right of each guess row.
module mastermind_board_renderer
   import mm_pkg::*;
#(
   parameter int COLS   = 4,
   parameter int ROWS   = 6,
   parameter int CBITS  = 3,
   parameter int SLOT   = 48,
   parameter int MARGIN = 16,
   parameter int X0     = 300,
   parameter int Y0     = 50
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                bright,
   input  logic [9:0]                          hCount,
   input  logic [9:0]                          vCount,
   input  logic [ROWS*COLS*CBITS-1:0]          matrix_flat,
   input  logic [ROWS*2*$clog2(COLS+1)-1:0]    fb_flat,
   input  logic [$clog2(ROWS)-1:0]             guess_num,
   input  logic [$clog2(COLS)-1:0]             cursor_index,
   input  logic [CBITS-1:0]                    current_color,
   input  logic                                q_Input,
   output logic [3:0]                          vgaR,
   output logic [3:0]                          vgaG,
   output logic [3:0]                          vgaB
);

   localparam int PITCH   = SLOT + MARGIN;
   localparam int FBW     = $clog2(COLS + 1);
   localparam int RW      = $clog2(ROWS);
   localparam int CW      = $clog2(COLS);
   localparam int NPC     = (COLS + 1) / 2;
   localparam int FX      = X0 + COLS * PITCH;
   localparam int GRID_W  = COLS * PITCH - MARGIN;
   localparam int GRID_H  = ROWS * PITCH - MARGIN;
   localparam int DISC_R2 = (SLOT / 3) * (SLOT / 3);

   if (X0 + COLS * PITCH + NPC * PEG_PITCH > 640) begin : g_width_check
      $error("mastermind_board_renderer: board plus feedback area exceeds 640 pixels");
   end

   // stage 1: pixel location
   logic          bright1_q, bright1_d;
   logic          blink1_q, blink1_d;
   region_t       region_q, region_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [9:0]    dx_q, dx_d;
   logic [9:0]    dy_q, dy_d;
   logic [4:0]    frame_q, frame_d;

   // stage 2: hit classification
   logic             bright2_q, bright2_d;
   logic             disc_hit_q, disc_hit_d;
   logic             border_q, border_d;
   logic [CBITS-1:0] sel_code_q, sel_code_d;

   // stage 3: colour
   rgb_t rgb_q, rgb_d;

   int   hoff;
   int   voff;
   int   cbase;
   int   rbase;
   int   dxi;
   int   dyi;
   logic in_v;
   logic in_slot;
   logic in_fb;
`ifdef MM_FEEDBACK_PEGS_EN
   int   fxoff;
`endif

   always_comb begin
      hoff  = int'(hCount) - X0;
      voff  = int'(vCount) - Y0;
      col_d = '0;
      cbase = 0;
      for (int i = 1; i < COLS; i++) begin
         if (hoff >= i * PITCH) begin
            col_d = CW'(i);
            cbase = i * PITCH;
         end
      end
      row_d = '0;
      rbase = 0;
      for (int i = 1; i < ROWS; i++) begin
         if (voff >= i * PITCH) begin
            row_d = RW'(i);
            rbase = i * PITCH;
         end
      end
      dxi     = hoff - cbase;
      dyi     = voff - rbase;
      in_v    = (voff >= 0) && (voff < GRID_H) && (dyi < SLOT);
      in_slot = in_v && (hoff >= 0) && (hoff < GRID_W) && (dxi < SLOT);
`ifdef MM_FEEDBACK_PEGS_EN
      fxoff   = int'(hCount) - FX;
      in_fb   = in_v && (fxoff >= 0) && (fxoff < NPC * PEG_PITCH);
`else
      in_fb   = 1'b0;
`endif
      region_d = REG_NONE;
      dx_d     = '0;
      dy_d     = '0;
      if (in_slot) begin
         region_d = REG_SLOT;
         dx_d     = 10'(dxi);
         dy_d     = 10'(dyi);
      end else if (in_fb) begin
         region_d = REG_FB;
`ifdef MM_FEEDBACK_PEGS_EN
         dx_d     = 10'(fxoff);
`endif
         dy_d     = 10'(dyi);
      end
      bright1_d = bright;
      blink1_d  = ~frame_q[4];
      frame_d   = (hCount == 10'd0 && vCount == 10'd0) ? frame_q + 5'd1 : frame_q;
   end

   logic [CBITS-1:0] code;
   int               ex;
   int               ey;
   int               dxq;
   int               dyq;
   logic             disc;
   logic             rim_px;
   logic             act_row;
   logic             preview;

   always_comb begin
      code = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (row_q == RW'(r) && col_q == CW'(c)) begin
               code = matrix_flat[(r*COLS+c)*CBITS +: CBITS];
            end
         end
      end
      dxq    = int'(dx_q);
      dyq    = int'(dy_q);
      ex     = dxq - SLOT / 2;
      ey     = dyq - SLOT / 2;
      disc   = (ex * ex + ey * ey) <= DISC_R2;
      rim_px = (dxq < 2) || (dxq >= SLOT - 2) || (dyq < 2) || (dyq >= SLOT - 2);
      // row_q/col_q never exceed ROWS-1/COLS-1, so out-of-range selectors never match
      act_row = q_Input && (row_q == guess_num);
      preview = act_row && blink1_q && (col_q == cursor_index) && (code == '0);

      bright2_d  = bright1_q;
      disc_hit_d = (region_q == REG_SLOT) && disc && ((code != '0) || preview);
      border_d   = (region_q == REG_SLOT) && act_row && rim_px && !disc;
      sel_code_d = preview ? current_color : code;
   end

`ifdef MM_FEEDBACK_PEGS_EN
   logic [FBW-1:0] fb_black;
   logic [FBW-1:0] fb_white;
   logic           peg_hit;
   rgb_t           peg_rgb;
   logic           peg_hit_q, peg_hit_d;
   rgb_t           peg_rgb_q, peg_rgb_d;

   always_comb begin
      fb_black = '0;
      fb_white = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_q == RW'(r)) begin
            fb_black = fb_flat[r*2*FBW +: FBW];
            fb_white = fb_flat[r*2*FBW+FBW +: FBW];
         end
      end
      peg_hit_d = (region_q == REG_FB) && peg_hit;
      peg_rgb_d = peg_rgb;
   end

   mm_feedback_pegs #(
      .COLS (COLS),
      .FBW  (FBW)
   ) u_pegs (
      .black (fb_black),
      .white (fb_white),
      .lx    (dx_q),
      .ly    (dy_q),
      .hit   (peg_hit),
      .rgb   (peg_rgb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peg_hit_q <= 1'b0;
         peg_rgb_q <= RGB_BLACK;
      end else begin
         peg_hit_q <= peg_hit_d;
         peg_rgb_q <= peg_rgb_d;
      end
   end
`else
   logic unused_fb;
   assign unused_fb = ^fb_flat;
`endif

   always_comb begin
      rgb_d = RGB_BLACK;
      if (bright2_q) begin
         if (border_q) begin
            rgb_d = RGB_WHITE;
         end else if (disc_hit_q) begin
            rgb_d = palette(32'(sel_code_q));
`ifdef MM_FEEDBACK_PEGS_EN
         end else if (peg_hit_q) begin
            rgb_d = peg_rgb_q;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bright1_q  <= 1'b0;
         blink1_q   <= 1'b0;
         region_q   <= REG_NONE;
         row_q      <= '0;
         col_q      <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         frame_q    <= '0;
         bright2_q  <= 1'b0;
         disc_hit_q <= 1'b0;
         border_q   <= 1'b0;
         sel_code_q <= '0;
         rgb_q      <= RGB_BLACK;
      end else begin
         bright1_q  <= bright1_d;
         blink1_q   <= blink1_d;
         region_q   <= region_d;
         row_q      <= row_d;
         col_q      <= col_d;
         dx_q       <= dx_d;
         dy_q       <= dy_d;
         frame_q    <= frame_d;
         bright2_q  <= bright2_d;
         disc_hit_q <= disc_hit_d;
         border_q   <= border_d;
         sel_code_q <= sel_code_d;
         rgb_q      <= rgb_d;
      end
   end

   assign vgaR = rgb_q[11:8];
   assign vgaG = rgb_q[7:4];
   assign vgaB = rgb_q[3:0];

endmodule

// File: doc/mastermind_board_renderer.md
MASTERMIND_BOARD_RENDERER -- requirements
Module: mastermind_board_renderer

Interface
REQ-001 SHALL have parameter COLS, default 4, meaning code pegs per guess row (2..8).
REQ-002 SHALL have parameter ROWS, default 6, meaning guess rows (2..12).
REQ-003 SHALL have parameter CBITS, default 3, meaning bits per colour code.
REQ-004 SHALL have parameters SLOT 48, MARGIN 16, X0 300, Y0 50, meaning slot size, gap, grid origin in pixels; PITCH = SLOT+MARGIN.
REQ-005 SHALL have ports: clk  in  1  pixel clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: bright in 1 active video; hCount in 10 column; vCount in 10 line.
REQ-007 SHALL have ports: matrix_flat in ROWS*COLS*CBITS board codes, row r col c at [(r*COLS+c)*CBITS +: CBITS]; fb_flat in ROWS*2*FBW feedback, FBW=$clog2(COLS+1), row r black at [r*2*FBW +: FBW], white directly above.
REQ-008 SHALL have ports: guess_num in $clog2(ROWS) active row; cursor_index in $clog2(COLS) cursor column; current_color in CBITS preview code; q_Input in 1 input mode active.
REQ-009 SHALL have ports: vgaR, vgaG, vgaB out 4 each, colour output.

Function
REQ-010 SHALL be a 3-stage pipeline: S1 registers bright, region, row, col, dx, dy; S2 registers circle/border/peg hit flags plus selected code; S3 registers vgaR/G/B; latency exactly 2 clk from hCount/vCount/bright sample to output change... i.e. output at edge N+2 reflects inputs sampled at edge N.
REQ-011 SHALL derive row/col without divider: compare-chain against multiples of PITCH, synthesis-time constant.
REQ-012 SHALL treat grid region as X0<=h<X0+COLS*PITCH-MARGIN, Y0<=v<Y0+ROWS*PITCH-MARGIN; margins render 000.
REQ-013 SHALL fill slot disc where (dx-SLOT/2)^2+(dy-SLOT/2)^2 <= (SLOT/3)^2 using stored code via palette: 0 none, 1 00F, 2 0F0, 3 0FF, 4 F00, 5 FF0, 6 F0F, >=7 888.
REQ-014 SHALL, when stored code==0, row==guess_num, col==cursor_index, q_Input=1 and blink phase visible, fill disc with palette(current_color).
REQ-015 SHALL draw 2-pixel FFF slot border outside disc on every slot of row guess_num while q_Input=1 (not blinked).
REQ-016 SHALL keep a 5-bit frame counter incremented once per frame when hCount==0 and vCount==0; blink phase visible when counter[4]==0; counter wraps 31->0.
REQ-017 SHALL treat all out-of-range indices (guess_num>=ROWS, cursor_index>=COLS) as no match.
REQ-018 SHALL drive 000 for the whole pixel when bright sampled low, propagated through the pipeline.
REQ-019 SHALL require X0+COLS*PITCH+((COLS+1)/2)*24 <= 640; violation is an elaboration error.

Reset
REQ-020 SHALL, with rst_n low, asynchronously clear vgaR/G/B to 0, all pipeline registers to 0 (bright flags low), frame counter to 0.
REQ-021 SHALL, after rst_n release mid-frame, output 000 for first 2 clk then normal rendering; blink restarts visible.

Configuration
REQ-022 SHALL, with MM_FEEDBACK_PEGS_EN defined, render feedback cell right of each row at FX=X0+COLS*PITCH: pegs on 24x24 pitch, (COLS+1)/2 across, 2 down, peg k=r*((COLS+1)/2)+c, disc radius^2<=49 about cell centre; k<black F00, k<black+white FFF, else 222.
REQ-023 SHALL, without MM_FEEDBACK_PEGS_EN, ignore fb_flat, keep the port, render feedback area 000, and omit peg logic.

Structure
REQ-024 SHALL place palette function, colour-code localparams, and 12-bit RGB type in shared package mm_pkg.
REQ-025 SHALL implement feedback peg decode as sub-module mm_feedback_pegs (row feedback, local peg coords in -> hit, 12-bit colour out).

Verification
REQ-026 Row0 col0 code 1, drive (324,74) bright=1 -> vga 0/0/F exactly 2 clk later, 000 at 1 clk.
REQ-027 guess_num=0, q_Input=1, pixel (300,50) -> FFF; same with q_Input=0 -> 000.
REQ-028 Row2 col1 code 0, guess_num=2, cursor_index=1, current_color=5, pixel (388,202): frames 0-15 -> FF0, frames 16-31 -> 000, frame 32 -> FF0.
REQ-029 MM_FEEDBACK_PEGS_EN, row0 black=2 white=1: (568,62) F00, (592,62) F00, (568,86) FFF, (592,86) 222; undefined -> all 000.
REQ-030 bright=0 at (324,74) with code 1 -> 000; rst_n pulsed low mid-line -> outputs 0 immediately, frame counter 0, valid output resumes 2 clk after release.
